// File: rtl/adder_share_scheduler.sv
// adder_share_scheduler: one shared sign-magnitude adder time-multiplexed across
// NUM_CH accumulation channels. Round-robin grant, one-stage operand capture,
// writeback one edge later into per-channel saturating accumulators.

// Per-channel accumulator and sticky overflow flag; clear outranks writeback.
module adder_share_lane (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iClear,
  input  logic        iWrEn,
  input  logic [30:0] iWrData,
  input  logic        iWrOvf,
  output logic [30:0] oAcc,
  output logic        oOvf
);
  // Accumulator register: clear drops any same-edge writeback.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oAcc <= '0;
      oOvf <= 1'b0;
    end else if (iClear) begin
      oAcc <= '0;
      oOvf <= 1'b0;
    end else if (iWrEn) begin
      oAcc <= iWrData;
      if (iWrOvf) oOvf <= 1'b1;
    end
  end
endmodule

module adder_share_scheduler #(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = 2
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic [NUM_CH*31-1:0] iTerm,
  input  logic [NUM_CH-1:0]   iValid,
  output logic [NUM_CH-1:0]   oReady,
  input  logic [NUM_CH-1:0]   iClear,
  output logic [NUM_CH*31-1:0] oAcc,
  output logic [NUM_CH-1:0]   oOvf,
  output logic                oBusy
);
  // -0 is not a legal value; the adder treats it as an overflow trigger.
  localparam logic [30:0] UNIT = {1'b1, 30'b0};

  typedef struct packed {
    logic [PTR_W-1:0] ch;
    logic [30:0]      opA;
    logic [30:0]      opB;
  } stageOp_t;

  logic [NUM_CH-1:0][30:0] termArr;
  logic [NUM_CH-1:0][30:0] accArr;
  logic [NUM_CH-1:0]       eligible;
  logic [NUM_CH-1:0]       grant;
  logic [NUM_CH-1:0]       wrEn;
  logic [PTR_W-1:0]        rrPtr;
  logic [PTR_W-1:0]        gIdx;
  logic [PTR_W-1:0]        nextPtr;
  logic                    found;
  logic                    stgBValid;
  stageOp_t                stgB;
  logic [30:0]             addSum;
  logic                    addOvf;
  logic [30:0]             wrData;

  assign termArr = iTerm;
  assign accArr  = oAcc;

  // Sign-magnitude add: {overflow, sign, magnitude}. Zero results are always +0.
  function automatic logic [31:0] smAdd(input logic [30:0] a, input logic [30:0] b);
    logic [30:0] mag;
    logic        sgn;
    logic        ovf;
    mag = '0;
    sgn = 1'b0;
    ovf = 1'b0;
    if (a == UNIT || b == UNIT) begin
      ovf = 1'b1;
    end else if (a[30] == b[30]) begin
      mag = {1'b0, a[29:0]} + {1'b0, b[29:0]};
      ovf = mag[30];
      sgn = a[30];
    end else if (a[29:0] >= b[29:0]) begin
      mag = {1'b0, a[29:0] - b[29:0]};
      sgn = a[30];
    end else begin
      mag = {1'b0, b[29:0] - a[29:0]};
      sgn = b[30];
    end
    if (mag[29:0] == '0) sgn = 1'b0;
    return {ovf, sgn, mag[29:0]};
  endfunction

  // Eligibility: valid, not being cleared, and not already waiting in stage B.
  always_comb begin
    eligible = '0;
    for (int c = 0; c < NUM_CH; c++)
      eligible[c] = iValid[c] & ~iClear[c] & ~(stgBValid & (stgB.ch == PTR_W'(c)));
  end

  // Round-robin scan starting at rrPtr with wrap at NUM_CH-1.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gIdx  = '0;
    grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rrPtr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        gIdx  = idx[PTR_W-1:0];
      end
    end
    if (found) grant[gIdx] = 1'b1;
  end

  assign nextPtr = (gIdx == PTR_W'(NUM_CH - 1)) ? '0 : gIdx + 1'b1;
  // Grant is combinational on iValid; forced low while reset is held.
  assign oReady  = grant & {NUM_CH{iRst_n}};
  assign oBusy   = stgBValid;

  // Stage A: capture the granted term and that channel's current accumulator.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stgBValid <= 1'b0;
      rrPtr     <= '0;
      stgB      <= '0;
    end else begin
      stgBValid <= found;
      if (found) begin
        stgB  <= '{ch: gIdx, opA: termArr[gIdx], opB: accArr[gIdx]};
        rrPtr <= nextPtr;
      end
    end
  end

  // Stage B: shared adder and saturation select for the writeback word.
  always_comb begin
    logic [31:0] res;
    res    = smAdd(stgB.opA, stgB.opB);
    addOvf = res[31];
    addSum = res[30:0];
    wrData = addOvf ? {stgB.opA[30], 30'h3FFFFFFF} : addSum;
  end

  // Writeback targets only the channel held in stage B.
  always_comb begin
    wrEn = '0;
    for (int c = 0; c < NUM_CH; c++)
      wrEn[c] = stgBValid & (stgB.ch == PTR_W'(c));
  end

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : gLane
      adder_share_lane uLane (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iClear  (iClear[c]),
        .iWrEn   (wrEn[c]),
        .iWrData (wrData),
        .iWrOvf  (addOvf),
        .oAcc    (oAcc[c*31 +: 31]),
        .oOvf    (oOvf[c])
      );
    end
  endgenerate
endmodule

// File: tb/tb_adder_share_scheduler.sv
// Bench for adder_share_scheduler: integer-arithmetic reference model checked every
// negedge, plus directed scenarios with literal expectations.
module tb_adder_share_scheduler;
  localparam int N = 4;

  logic           iClk = 1'b0;
  logic           iRst_n = 1'b0;
  logic [N*31-1:0] iTerm = '0;
  logic [N-1:0]   iValid = '0;
  logic [N-1:0]   iClear = '0;
  logic [N-1:0]   oReady;
  logic [N*31-1:0] oAcc;
  logic [N-1:0]   oOvf;
  logic           oBusy;

  int nChecks = 0;
  int nPass = 0;

  adder_share_scheduler #(.NUM_CH(N), .PTR_W(2)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iTerm(iTerm), .iValid(iValid),
    .oReady(oReady), .iClear(iClear), .oAcc(oAcc), .oOvf(oOvf), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [30:0] accOf(input int c);
    return oAcc[c*31 +: 31];
  endfunction

  // Reference model state (post-edge view of the DUT).
  logic [30:0] mAcc [N];
  logic        mOvf [N];
  logic        mPend;
  int          mPendCh;
  logic [30:0] mA, mB;
  int          mPtr;

  // Signed-integer add with saturation at +/-(2^30-1); returns {ovf, word}.
  function automatic logic [31:0] mAdd(input logic [30:0] a, input logic [30:0] b);
    longint va, vb, s;
    longint maxM;
    logic [29:0] m;
    maxM = (longint'(1) << 30) - 1;
    if (a == 31'h40000000 || b == 31'h40000000) return {1'b1, a[30], 30'h3FFFFFFF};
    va = a[30] ? -longint'(a[29:0]) : longint'(a[29:0]);
    vb = b[30] ? -longint'(b[29:0]) : longint'(b[29:0]);
    s = va + vb;
    if (s > maxM || s < -maxM) return {1'b1, a[30], 30'h3FFFFFFF};
    if (s < 0) begin m = 30'(-s); return {1'b0, 1'b1, m}; end
    m = 30'(s);
    return {1'b0, 1'b0, m};
  endfunction

  // Compare DUT against model, then advance model across the coming posedge.
  always @(negedge iClk) begin
    logic [N-1:0] expRdy;
    logic [31:0]  r;
    int g, c;
    if (!iRst_n) begin
      for (int k = 0; k < N; k++) begin mAcc[k] = '0; mOvf[k] = 1'b0; end
      mPend = 1'b0; mPendCh = 0; mPtr = 0; mA = '0; mB = '0;
    end
    expRdy = '0;
    g = -1;
    if (iRst_n)
      for (int i = 0; i < N; i++) begin
        c = (mPtr + i) % N;
        if (g < 0 && iValid[c] && !iClear[c] && !(mPend && mPendCh == c)) g = c;
      end
    if (g >= 0) expRdy[g] = 1'b1;
    chk("ready", 32'(oReady), 32'(expRdy));
    chk("busy", 32'(oBusy), 32'(mPend));
    for (int k = 0; k < N; k++) begin
      chk($sformatf("acc%0d", k), 32'(accOf(k)), 32'(mAcc[k]));
      chk($sformatf("ovf%0d", k), 32'(oOvf[k]), 32'(mOvf[k]));
    end
    if (iRst_n) begin
      if (mPend && !iClear[mPendCh]) begin
        r = mAdd(mA, mB);
        mAcc[mPendCh] = r[30:0];
        if (r[31]) mOvf[mPendCh] = 1'b1;
      end
      for (int k = 0; k < N; k++)
        if (iClear[k]) begin mAcc[k] = '0; mOvf[k] = 1'b0; end
      mPend = (g >= 0);
      if (g >= 0) begin
        mA = iTerm[g*31 +: 31];
        mB = mAcc[g];
        mPendCh = g;
        mPtr = (g + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic send(input int c, input logic [30:0] t);
    iTerm[c*31 +: 31] = t;
    iValid[c] = 1'b1;
    step();
    iValid[c] = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("%0d/%0d checks passed", nPass, nChecks);
    $fatal(1);
  end

  initial begin
    step(); step();
    chk("rst_acc", 32'(oAcc[30:0]), 32'h0);
    chk("rst_rdy", 32'(oReady), 32'h0);
    chk("rst_busy", 32'(oBusy), 32'h0);
    iRst_n = 1'b1;
    step();

    // T1: reset while ch0 op is in stage B
    send(0, 31'd7);
    chk("t1_pre", 32'(accOf(0)), 32'h7);
    iTerm[30:0] = 31'd5;
    iValid[0] = 1'b1;
    step();
    chk("t1_busy", 32'(oBusy), 32'h1);
    iValid[0] = 1'b0;
    iRst_n = 1'b0;
    step();
    iRst_n = 1'b1;
    step();
    chk("t1_acc0", 32'(accOf(0)), 32'h0);
    chk("t1_ovf", 32'(oOvf), 32'h0);

    // T2: latency and one-cycle busy
    send(1, 31'h3);
    iTerm[1*31 +: 31] = 31'h5;
    iValid[1] = 1'b1;
    #1 chk("t2_rdy", 32'(oReady), 32'h2);
    step();
    chk("t2_busy", 32'(oBusy), 32'h1);
    iValid[1] = 1'b0;
    step();
    chk("t2_acc", 32'(accOf(1)), 32'h8);
    chk("t2_model", 32'(mAcc[1]), 32'h8);
    chk("t2_idle", 32'(oBusy), 32'h0);

    // T3: round-robin from pointer 0 with all channels requesting
    iRst_n = 1'b0;
    step();
    iRst_n = 1'b1;
    for (int k = 0; k < N; k++) iTerm[k*31 +: 31] = 31'd1;
    iValid = '1;
    for (int i = 0; i < 8; i++) begin
      #1 chk($sformatf("t3_grant%0d", i), 32'(oReady), 32'(1) << (i % 4));
      step();
    end
    iValid = '0;
    step();
    chk("t3_acc3", 32'(accOf(3)), 32'h2);

    // T4: overflow saturates, then subtraction moves off saturation
    iClear[0] = 1'b1;
    step();
    iClear[0] = 1'b0;
    send(0, 31'h3FFFFFF0);
    send(0, 31'h00000020);
    chk("t4_sat", 32'(accOf(0)), 32'h3FFFFFFF);
    chk("t4_ovf", 32'(oOvf[0]), 32'h1);
    send(0, 31'h40000010);
    chk("t4_sub", 32'(accOf(0)), 32'h3FFFFFEF);
    chk("t4_model", 32'(mAcc[0]), 32'h3FFFFFEF);
    chk("t4_sticky", 32'(oOvf[0]), 32'h1);

    // T5: mixed signs, zero result is +0
    iClear[3] = 1'b1;
    step();
    iClear[3] = 1'b0;
    send(3, 31'h0000000A);
    send(3, 31'h4000000A);
    chk("t5_zero", 32'(accOf(3)), 32'h0);
    send(3, 31'h40000004);
    chk("t5_neg", 32'(accOf(3)), 32'h40000004);
    chk("t5_model", 32'(mAcc[3]), 32'h40000004);

    // T6: unit-code saturation, then clear collides with writeback
    send(2, 31'h40000000);
    chk("t6_unit", 32'(accOf(2)), 32'h7FFFFFFF);
    chk("t6_uovf", 32'(oOvf[2]), 32'h1);
    iTerm[2*31 +: 31] = 31'd9;
    iValid[2] = 1'b1;
    step();
    iTerm[2*31 +: 31] = 31'd3;
    iClear[2] = 1'b1;
    #1 chk("t6_rdy", 32'(oReady[2]), 32'h0);
    step();
    iClear[2] = 1'b0;
    iValid[2] = 1'b0;
    chk("t6_acc", 32'(accOf(2)), 32'h0);
    chk("t6_ovf", 32'(oOvf[2]), 32'h0);
    step();
    chk("t6_hold", 32'(accOf(2)), 32'h0);

    // Clear masks ready even with no stage-B hazard
    iClear[1] = 1'b1;
    iValid[1] = 1'b1;
    #1 chk("clr_rdy", 32'(oReady), 32'h0);
    step();
    iClear[1] = 1'b0;
    iValid[1] = 1'b0;
    step();
    chk("clr_acc1", 32'(accOf(1)), 32'h0);

    step();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
